// File: rtl/tlv5618_if.sv
// Update request / DAC frame handshake bundle between the TLV5618 controller and its environment.
// master = requester plus serial driver side, slave = controller.
interface tlv5618_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [11:0] ch_a;
    logic [11:0] ch_b;
    logic [15:0] DAC_DATA;
    logic        Start;
    logic        Set_Done;
    logic        busy;
    logic        timeout_err;

    modport master (
        output upd_valid, ch_a, ch_b, Set_Done,
        input  upd_ready, DAC_DATA, Start, busy, timeout_err
    );

    modport slave (
        input  upd_valid, ch_a, ch_b, Set_Done,
        output upd_ready, DAC_DATA, Start, busy, timeout_err
    );
endinterface

// File: rtl/tlv5618_ctrl.sv
// Purpose: turns one (ch_a, ch_b) update into a buffered B word then an A word for a TLV5618 serial driver.
// Latency: word B Start one cycle after acceptance; word A Start one cycle after Set_Done of word B.
// Backpressure: upd_ready only in IDLE; each Set_Done wait is bounded by TIMEOUT_CYCLES (sticky error).
module tlv5618_ctrl #(
    parameter bit SPD            = 1'b1,
    parameter bit PWR            = 1'b0,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic      clk,
    input logic      rst_n,
    tlv5618_if.slave bus
);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    typedef enum logic [2:0] {IDLE, SEND_B, WAIT_B, SEND_A, WAIT_A, GAP} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [11:0] cap_a;
    logic [15:0] dac_data;
    logic        timeout_err;
    logic        accept;
    logic        expire;
    logic        load_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Set_Done is checked before the timeout compare so a coincident pulse still completes the word.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        expire    = 1'b0;
        load_a    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.upd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SEND_B;
                end
            end
            SEND_B: state_nxt = WAIT_B;
            WAIT_B: begin
                if (bus.Set_Done) begin
                    load_a    = 1'b1;
                    state_nxt = SEND_A;
                end else if (cnt == TO_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SEND_A: state_nxt = WAIT_A;
            WAIT_A: begin
                if (bus.Set_Done) begin
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if (cnt == TO_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_data    <= 16'h0000;
            cap_a       <= 12'h000;
            timeout_err <= 1'b0;
            cnt         <= 16'd0;
        end else begin
            if (accept) begin
                dac_data <= {1'b0, SPD, PWR, 1'b1, bus.ch_b};
                cap_a    <= bus.ch_a;
            end else if (load_a) begin
                dac_data <= {1'b1, SPD, PWR, 1'b0, cap_a};
            end

            if (accept)      timeout_err <= 1'b0;
            else if (expire) timeout_err <= 1'b1;

            // One counter serves both wait timeouts and the inter-update gap; it restarts on every state change.
            if (state_nxt != state)                    cnt <= 16'd0;
            else if (state inside {WAIT_B, WAIT_A, GAP}) cnt <= cnt + 16'd1;
        end
    end

    assign bus.DAC_DATA    = dac_data;
    assign bus.Start       = (state == SEND_B) || (state == SEND_A);
    assign bus.busy        = (state != IDLE);
    assign bus.upd_ready   = (state == IDLE);
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_tlv5618_ctrl.sv
// Bench for tlv5618_ctrl: default-parameter instance for the update flow, short-timeout/no-gap instance for error paths.
module tb_tlv5618_ctrl;
    localparam bit SPD = 1'b1;
    localparam bit PWR = 1'b0;
    localparam int GAP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tlv5618_if bus();
    tlv5618_if bus2();

    tlv5618_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    tlv5618_ctrl #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        int          db;
        int          da;
        bit          spur;
        logic [15:0] exp_b;
        logic [15:0] exp_a;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference word: R1 at 2^15, SPD at 2^14, PWR at 2^13, R0 at 2^12, data below.
    function automatic logic [15:0] model_word(input bit is_a, input logic [11:0] d);
        int w;
        w = (is_a ? 32768 : 0) + (SPD ? 16384 : 0) + (PWR ? 8192 : 0) + (is_a ? 0 : 4096) + int'(d);
        return w[15:0];
    endfunction

    task automatic scramble();
        bus.ch_a = 12'($urandom);
        bus.ch_b = 12'($urandom);
    endtask

    // Holds Set_Done low for d-1 WAIT cycles, pulses it on the d-th, returns at the following negedge.
    task automatic wait_done(input int d, input logic [15:0] held);
        for (int i = 1; i <= d; i++) begin
            scramble();
            @(negedge clk);
            check("no_start_in_wait", bus.Start, 1'b0);
            check("word_held", bus.DAC_DATA, held);
            check("ready_low_wait", bus.upd_ready, 1'b0);
        end
        bus.Set_Done = 1'b1;
        scramble();
        @(negedge clk);
        bus.Set_Done = 1'b0;
    endtask

    task automatic run_pair(input logic [11:0] a, input logic [11:0] b, input int db, input int da,
                            input bit spur, input bit hold, input logic [15:0] exp_b, input logic [15:0] exp_a);
        int k;
        check("ready_before", bus.upd_ready, 1'b1);
        bus.upd_valid = 1'b1;
        bus.ch_a = a;
        bus.ch_b = b;
        @(negedge clk);
        check("start_b", bus.Start, 1'b1);
        check("word_b", bus.DAC_DATA, exp_b);
        check("busy_b", bus.busy, 1'b1);
        check("ready_low", bus.upd_ready, 1'b0);
        bus.upd_valid = hold;
        wait_done(db, exp_b);
        check("start_a", bus.Start, 1'b1);
        check("word_a", bus.DAC_DATA, exp_a);
        wait_done(da, exp_a);
        k = 1;
        while (!bus.upd_ready && k < 64) begin
            check("no_start_gap", bus.Start, 1'b0);
            check("busy_gap", bus.busy, 1'b1);
            bus.Set_Done = spur ? ~bus.Set_Done : 1'b0;
            scramble();
            @(negedge clk);
            k++;
        end
        bus.Set_Done = 1'b0;
        check("gap_len", k, GAP + 1);
        check("idle_not_busy", bus.busy, 1'b0);
        check("idle_no_start", bus.Start, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [11:0] ra, rb;

        vecs[0] = '{12'h123, 12'hABC, 40, 40, 1'b0, 16'h5ABC, 16'hC123};
        vecs[1] = '{12'h000, 12'h000,  1,  1, 1'b0, 16'h5000, 16'hC000};
        vecs[2] = '{12'hFFF, 12'hFFF,  3,  7, 1'b1, 16'h5FFF, 16'hCFFF};
        vecs[3] = '{12'h800, 12'h001,  2,  1, 1'b1, 16'h5001, 16'hC800};
        vecs[4] = '{12'h5A5, 12'h3C3, 17,  9, 1'b0, 16'h53C3, 16'hC5A5};

        rst_n = 1'b0;
        bus.upd_valid = 1'b0;  bus.ch_a = '0;  bus.ch_b = '0;  bus.Set_Done = 1'b0;
        bus2.upd_valid = 1'b0; bus2.ch_a = '0; bus2.ch_b = '0; bus2.Set_Done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dac", bus.DAC_DATA, 16'h0000);
        check("rst_start", bus.Start, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err", bus.timeout_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.upd_ready, 1'b1);

        for (int i = 0; i < 5; i++)
            run_pair(vecs[i].a, vecs[i].b, vecs[i].db, vecs[i].da, vecs[i].spur, 1'b0,
                     vecs[i].exp_b, vecs[i].exp_a);

        for (int i = 0; i < 20; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            run_pair(ra, rb, int'($urandom_range(1, 50)), int'($urandom_range(1, 50)),
                     1'($urandom), 1'b0, model_word(1'b0, rb), model_word(1'b1, ra));
        end

        // Back-to-back: upd_valid stays high, channels churn while busy.
        run_pair(12'h111, 12'h222, 5, 6, 1'b0, 1'b1, model_word(1'b0, 12'h222), model_word(1'b1, 12'h111));
        run_pair(12'h333, 12'h444, 3, 3, 1'b0, 1'b0, model_word(1'b0, 12'h444), model_word(1'b1, 12'h333));

        // Asynchronous reset while waiting on word A.
        bus.upd_valid = 1'b1; bus.ch_a = 12'h777; bus.ch_b = 12'h888;
        @(negedge clk);
        bus.upd_valid = 1'b0;
        wait_done(2, 16'h5888);
        check("start_a_pre_rst", bus.Start, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dac", bus.DAC_DATA, 16'h0000);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_start", bus.Start, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.Set_Done = 1'($urandom);
            @(negedge clk);
            check("post_rst_no_start", bus.Start, 1'b0);
            check("post_rst_ready", bus.upd_ready, 1'b1);
        end
        bus.Set_Done = 1'b0;
        run_pair(12'h9AB, 12'hCDE, 4, 4, 1'b0, 1'b0, 16'h5CDE, 16'hC9AB);

        // Short-timeout instance: expiry in WAIT_B, then coincident Set_Done at expiry.
        check("to_ready", bus2.upd_ready, 1'b1);
        bus2.upd_valid = 1'b1; bus2.ch_a = 12'h321; bus2.ch_b = 12'h654;
        @(negedge clk);
        bus2.upd_valid = 1'b0;
        check("to_start_b", bus2.Start, 1'b1);
        check("to_word_b", bus2.DAC_DATA, 16'h5654);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("to_pending", bus2.timeout_err, 1'b0);
            check("to_wait_busy", bus2.busy, 1'b1);
        end
        @(negedge clk);
        check("to_err_set", bus2.timeout_err, 1'b1);
        check("to_idle", bus2.upd_ready, 1'b1);
        check("to_not_busy", bus2.busy, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("to_no_word_a", bus2.Start, 1'b0);
            check("to_err_sticky", bus2.timeout_err, 1'b1);
        end
        bus2.upd_valid = 1'b1; bus2.ch_a = 12'h0AA; bus2.ch_b = 12'h055;
        @(negedge clk);
        bus2.upd_valid = 1'b0;
        check("to_err_cleared", bus2.timeout_err, 1'b0);
        check("to2_word_b", bus2.DAC_DATA, 16'h5055);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("to2_no_start", bus2.Start, 1'b0);
            if (k == 16) bus2.Set_Done = 1'b1;
        end
        @(negedge clk);
        bus2.Set_Done = 1'b0;
        check("coinc_start_a", bus2.Start, 1'b1);
        check("coinc_word_a", bus2.DAC_DATA, 16'hC0AA);
        check("coinc_no_err", bus2.timeout_err, 1'b0);
        @(negedge clk);
        bus2.Set_Done = 1'b1;
        @(negedge clk);
        bus2.Set_Done = 1'b0;
        check("nogap_ready", bus2.upd_ready, 1'b1);
        check("nogap_err", bus2.timeout_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tlv5618_ctrl.md
TLV5618_CTRL -- requirements
Module: tlv5618_ctrl

Interface
REQ-001 Parameter SPD, default 1: speed bit placed in control word bit 14 (1 = fast mode).
REQ-002 Parameter PWR, default 0: power-down bit placed in control word bit 13 (1 = power down).
REQ-003 Parameter GAP_CYCLES, default 4: idle clocks after a completed update pair before the next is accepted; range 0..255.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: max clocks waited for Set_Done per word; range 2..65535.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 upd_valid  in  1  update request; ch_a/ch_b valid while high.
REQ-008 upd_ready  out  1  block can accept an update this cycle.
REQ-009 ch_a  in  12  channel A code.
REQ-010 ch_b  in  12  channel B code.
REQ-011 DAC_DATA  out  16  control word to serial DAC driver.
REQ-012 Start  out  1  one-cycle pulse launching one DAC_DATA frame in the driver.
REQ-013 Set_Done  in  1  one-cycle pulse from driver: current frame fully shifted out.
REQ-014 busy  out  1  high from acceptance until return to IDLE.
REQ-015 timeout_err  out  1  sticky: a Set_Done wait exceeded TIMEOUT_CYCLES.

Function
REQ-016 Control word format: [15]=R1, [14]=SPD, [13]=PWR, [12]=R0, [11:0]=data.
REQ-017 Word B = {R1=0, SPD, PWR, R0=1, captured ch_b} (write buffer only); word A = {R1=1, SPD, PWR, R0=0, captured ch_a} (write DAC A, update DAC B from buffer).
REQ-018 States: IDLE, SEND_B, WAIT_B, SEND_A, WAIT_A, GAP.
REQ-019 upd_ready = 1 only in IDLE; transfer occurs on cycle T with upd_valid & upd_ready; ch_a/ch_b captured at T; IDLE->SEND_B.
REQ-020 Accepting a transfer clears timeout_err.
REQ-021 SEND_B (cycle T+1): Start=1, DAC_DATA=word B; next state WAIT_B.
REQ-022 WAIT_B: Start=0, DAC_DATA held at word B; on Set_Done -> SEND_A.
REQ-023 SEND_A: Start=1 for one cycle, DAC_DATA=word A; next WAIT_A; DAC_DATA held until Set_Done.
REQ-024 WAIT_A: on Set_Done -> GAP if GAP_CYCLES>0, else IDLE.
REQ-025 GAP: count GAP_CYCLES clocks then IDLE; upd_ready first high on the cycle IDLE is entered.
REQ-026 Word A Start never precedes Set_Done of word B; exactly one Start pulse per word.
REQ-027 Timeout counter clears on entry to WAIT_B/WAIT_A, increments each WAIT cycle; reaching TIMEOUT_CYCLES without Set_Done -> timeout_err=1, state IDLE, pending word dropped.
REQ-028 Set_Done on same cycle as timeout expiry: Set_Done wins, no error.
REQ-029 Set_Done in IDLE, SEND_x or GAP: ignored, no state change.
REQ-030 upd_valid while upd_ready=0: ignored; ch_a/ch_b changes after capture do not affect words in flight.
REQ-031 busy = 1 in all states except IDLE.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, DAC_DATA=16'h0000, Start=0, busy=0, timeout_err=0, counters 0; upd_ready=1 from first clock after rst_n rises.
REQ-033 Reset mid-sequence aborts without further Start pulses; no partial word re-issued after release.

Verification
REQ-034 SPD=1, PWR=0, ch_a=12'h123, ch_b=12'hABC, Set_Done 40 clocks after each Start -> Start with DAC_DATA=16'h5ABC at T+1, then Start with 16'hC123 one cycle after first Set_Done; upd_ready high GAP_CYCLES+1 clocks after second Set_Done.
REQ-035 Back-to-back upd_valid held high with ch_a/ch_b changing mid-sequence -> second pair accepted only after GAP; words in flight unchanged.
REQ-036 Set_Done never asserted, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT_B cycles, no word A Start, state IDLE; next accept clears timeout_err.
REQ-037 Set_Done coincident with timeout expiry -> proceeds to SEND_A, timeout_err stays 0.
REQ-038 rst_n low during WAIT_A -> all outputs at reset values immediately (asynchronous), no Start after release until new upd_valid.
REQ-039 Spurious Set_Done pulses in IDLE and GAP -> no Start, no state change, GAP length unchanged.
